// File: rtl/unary_pkg.sv
// Shared types and sizing/conversion helpers for the temporal-unary decoder.
package unary_pkg;

    typedef enum logic {IDLE, ACCUM} state_t;

    function automatic int unsigned frame_len(input int unsigned size);
        return (1 << size) + 2;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned size);
        return $clog2(frame_len(size) + 1);
    endfunction

    function automatic int unsigned max_mag(input int unsigned size);
        return (1 << size) - 1;
    endfunction

    function automatic int unsigned sat_mag(input int unsigned cnt, input int unsigned size);
        return (cnt > max_mag(size)) ? max_mag(size) : cnt;
    endfunction

    // Caller keeps the low BIT_WIDTH bits; negative zero folds to zero.
    function automatic int unsigned to_twos(input int unsigned mag, input logic sign);
        return sign ? (~mag + 1) : mag;
    endfunction

endpackage

// File: rtl/unary_stream_decoder_if.sv
// Unary lane inputs plus the decoded-word valid/ready output channel.
interface unary_stream_decoder_if #(
    parameter int LANES     = 2,
    parameter int BIT_WIDTH = 5
);
    logic                              frame_start;
    logic [LANES-1:0]                  unary_in;
    logic [LANES-1:0]                  sign_in;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES-1:0][BIT_WIDTH-1:0]   out_data;
    logic [LANES-1:0]                  out_error;
    logic                              overrun;
    logic                              frame_abort;

    modport slave (
        input  frame_start, unary_in, sign_in, out_ready,
        output out_valid, out_data, out_error, overrun, frame_abort
    );

    modport master (
        output frame_start, unary_in, sign_in, out_ready,
        input  out_valid, out_data, out_error, overrun, frame_abort
    );
endinterface

// File: rtl/unary_lane_counter.sv
// One lane: counts ones over a frame, checks thermometer shape, and presents
// the value/error that would be committed if this cycle ends the frame.
module unary_lane_counter
    import unary_pkg::*;
#(
    parameter int BIT_WIDTH = 5,
    parameter int SIZE      = 4,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 acc,
    input  logic                 unary,
    input  logic                 sign_in,
    output logic [BIT_WIDTH-1:0] value,
    output logic                 err_out
);
    logic [CNT_W-1:0] count, cnt_nxt;
    logic             seen_zero, err, sign, err_nxt;

    // Next-state view includes this cycle's sample so the last frame cycle counts.
    always_comb begin
        cnt_nxt = count + CNT_W'(unary);
        err_nxt = err | (unary & seen_zero);
        value   = BIT_WIDTH'(to_twos(sat_mag(32'(cnt_nxt), SIZE), sign));
        err_out = err_nxt | (32'(cnt_nxt) > max_mag(SIZE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count     <= '0;
            seen_zero <= 1'b0;
            err       <= 1'b0;
            sign      <= 1'b0;
        end else if (load) begin
            count     <= CNT_W'(unary);
            seen_zero <= ~unary;
            err       <= 1'b0;
            sign      <= sign_in;
        end else if (acc) begin
            count <= cnt_nxt;
            err   <= err_nxt;
            if (!unary) seen_zero <= 1'b1;
        end
    end
endmodule

// File: rtl/unary_stream_decoder.sv
// Frame FSM, per-lane counters and a 1-entry valid/ready buffer that turns
// temporal-unary lanes back into signed binary words.
module unary_stream_decoder
    import unary_pkg::*;
#(
    parameter int BIT_WIDTH = 5,
    parameter int SIZE      = BIT_WIDTH - 1,
    parameter int LANES     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    unary_stream_decoder_if.slave  bus
);
    localparam int FRAME_LEN = frame_len(SIZE);
    localparam int CNT_W     = cnt_w(SIZE);

    state_t                          state;
    logic [CNT_W-1:0]                frame_cyc;
    logic                            last;
    logic [LANES-1:0][BIT_WIDTH-1:0] lane_val;
    logic [LANES-1:0]                lane_err;
    logic                            valid_q, overrun_q, abort_q;
    logic [LANES-1:0][BIT_WIDTH-1:0] data_q;
    logic [LANES-1:0]                error_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        unary_lane_counter #(.BIT_WIDTH(BIT_WIDTH), .SIZE(SIZE), .CNT_W(CNT_W)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load    (bus.frame_start),
            .acc     (state == ACCUM),
            .unary   (bus.unary_in[i]),
            .sign_in (bus.sign_in[i]),
            .value   (lane_val[i]),
            .err_out (lane_err[i])
        );
    end

    // frame_cyc holds the index of the frame cycle currently on the inputs.
    assign last = (state == ACCUM) && (frame_cyc == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            frame_cyc <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            error_q   <= '0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
            case (state)
                IDLE: if (bus.frame_start) begin
                    state     <= ACCUM;
                    frame_cyc <= CNT_W'(1);
                end
                ACCUM: if (bus.frame_start) begin
                    frame_cyc <= CNT_W'(1);
                    abort_q   <= !last;
                end else if (last) begin
                    state     <= IDLE;
                    frame_cyc <= '0;
                end else begin
                    frame_cyc <= frame_cyc + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase

            if (last) begin
                if (!valid_q || bus.out_ready) begin
                    valid_q <= 1'b1;
                    data_q  <= lane_val;
                    error_q <= lane_err;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_data    = data_q;
    assign bus.out_error   = error_q;
    assign bus.overrun     = overrun_q;
    assign bus.frame_abort = abort_q;
endmodule
